// File: rtl/control_seq.sv
// Multicycle control sequencer: fetches an opcode by handshake and steps
// FETCH->DECODE->EXEC->[MEM]->WB, driving registered datapath strobes per state.
module control_seq #(
  parameter int OPW         = 3,
  parameter int ALUOPW      = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              instr_valid,
  input  logic [OPW-1:0]    opcode,
  input  logic              br_logic,
  input  logic              mem_ready,
  output logic              instr_ready,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              ALUSrc,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              Branch,
  output logic              pc_en,
  output logic              mem_err,
  output logic              illegal,
  output logic              busy,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic load;
    logic store;
    logic branch;
  } dec_t;

  function automatic logic f_illegal(input logic [OPW-1:0] op);
    logic bad;
    bad = 1'b0;
    for (int b = 3; b < OPW; b++) bad = bad | op[b];
    return bad;
  endfunction

  function automatic logic [ALUOPW-1:0] f_aluop(input logic [OPW-1:0] op);
    if (f_illegal(op)) return '1;
    return ALUOPW'(op[2:0]);
  endfunction

  // Illegal opcodes decode to an all-zero strobe set: a NOP that still retires.
  function automatic dec_t f_decode(input logic [OPW-1:0] op);
    dec_t d;
    d = '0;
    if (!f_illegal(op)) begin
      case (op[2:0])
        3'd0: begin
          d.reg_write  = 1'b1;
          d.mem_to_reg = 1'b1;
          d.load       = 1'b1;
        end
        3'd1:    d.store     = 1'b1;
        3'd7:    d.branch    = 1'b1;
        default: d.reg_write = 1'b1;
      endcase
    end
    return d;
  endfunction

  state_t            r_state;
  logic [OPW-1:0]    r_ir;
  dec_t              r_dec;
  logic              r_br_q;
  logic [TW-1:0]     r_tmo_cnt;
  logic [CNT_W-1:0]  r_instr_count;
  logic [ALUOPW-1:0] r_aluop;
  logic              r_instr_ready;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic              r_reg_write;
  logic              r_branch;
  logic              r_pc_en;
  logic              r_mem_err;
  logic              r_illegal;
  logic              r_busy;

  dec_t              w_dec;
  logic [ALUOPW-1:0] w_aluop;
  logic [TW-1:0]     w_tmo_next;
  logic              w_tmo_hit;

  assign w_dec      = f_decode(r_ir);
  assign w_aluop    = f_aluop(r_ir);
  assign w_tmo_next = r_tmo_cnt + TW'(1);
  assign w_tmo_hit  = (MEM_TIMEOUT != 0) && (w_tmo_next == TW'(MEM_TIMEOUT));

  // Outputs are registered on the edge that enters the state they belong to,
  // so every strobe is valid for exactly the cycles spent in that state.
  // NOTE: all state and outputs use <= so every register updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ir          <= '0;
      r_dec         <= '0;
      r_br_q        <= 1'b0;
      r_tmo_cnt     <= '0;
      r_instr_count <= '0;
      r_aluop       <= '1;
      r_instr_ready <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_reg_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_pc_en       <= 1'b0;
      r_mem_err     <= 1'b0;
      r_illegal     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_pc_en      <= 1'b0;
      r_mem_err    <= 1'b0;
      r_illegal    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_FETCH;
            r_instr_ready <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        S_FETCH: begin
          if (instr_valid) begin
            r_state       <= S_DECODE;
            r_ir          <= opcode;
            r_illegal     <= f_illegal(opcode);
            r_instr_ready <= 1'b0;
          end else if (halt_req) begin
            r_state       <= S_IDLE;
            r_instr_ready <= 1'b0;
            r_busy        <= 1'b0;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
          r_dec   <= w_dec;
          r_br_q  <= br_logic;
          r_aluop <= w_aluop;
        end
        S_EXEC: begin
          if (r_dec.load || r_dec.store) begin
            r_state     <= S_MEM;
            r_mem_read  <= r_dec.load;
            r_mem_write <= r_dec.store;
            r_tmo_cnt   <= '0;
          end else begin
            r_state     <= S_WB;
            r_pc_en     <= 1'b1;
            r_reg_write <= r_dec.reg_write;
            r_branch    <= r_dec.branch & r_br_q;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state      <= S_WB;
            r_tmo_cnt    <= '0;
            r_pc_en      <= 1'b1;
            r_reg_write  <= r_dec.reg_write;
            r_mem_to_reg <= r_dec.mem_to_reg;
          end else if (w_tmo_hit) begin
            // Aborted access: retire without writing the register file.
            r_state   <= S_WB;
            r_tmo_cnt <= '0;
            r_pc_en   <= 1'b1;
            r_mem_err <= 1'b1;
          end else begin
            r_mem_read  <= r_dec.load;
            r_mem_write <= r_dec.store;
            if (MEM_TIMEOUT != 0) r_tmo_cnt <= w_tmo_next;
          end
        end
        S_WB: begin
          r_state       <= S_FETCH;
          r_instr_ready <= 1'b1;
          r_aluop       <= '1;
          if (r_instr_count != '1) r_instr_count <= r_instr_count + CNT_W'(1);
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_ready <= 1'b0;
          r_busy        <= 1'b0;
          r_aluop       <= '1;
        end
      endcase
    end
  end

  assign instr_ready = r_instr_ready;
  assign ALUOp       = r_aluop;
  assign ALUSrc      = 1'b0;
  assign MemRead     = r_mem_read;
  assign MemWrite    = r_mem_write;
  assign MemtoReg    = r_mem_to_reg;
  assign RegWrite    = r_reg_write;
  assign Branch      = r_branch;
  assign pc_en       = r_pc_en;
  assign mem_err     = r_mem_err;
  assign illegal     = r_illegal;
  assign busy        = r_busy;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: a main instance (OPW=4) and a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_control_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic       instr_valid = 1'b0;
  logic [3:0] opcode = '0;
  logic       br_logic = 1'b0;
  logic       mem_ready = 1'b0;

  logic        instr_ready, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite;
  logic        Branch, pc_en, mem_err, illegal, busy;
  logic [2:0]  ALUOp;
  logic [15:0] instr_count;

  logic        s_instr_ready, s_ALUSrc, s_MemRead, s_MemWrite, s_MemtoReg, s_RegWrite;
  logic        s_Branch, s_pc_en, s_mem_err, s_illegal, s_busy;
  logic [2:0]  s_ALUOp;
  logic [1:0]  s_instr_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  control_seq #(.OPW(4), .ALUOPW(3), .MEM_TIMEOUT(16), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .instr_valid(instr_valid), .opcode(opcode), .br_logic(br_logic), .mem_ready(mem_ready),
    .instr_ready(instr_ready), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch),
    .pc_en(pc_en), .mem_err(mem_err), .illegal(illegal), .busy(busy),
    .instr_count(instr_count)
  );

  control_seq #(.OPW(4), .ALUOPW(3), .MEM_TIMEOUT(16), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .instr_valid(instr_valid), .opcode(opcode), .br_logic(br_logic), .mem_ready(mem_ready),
    .instr_ready(s_instr_ready), .ALUOp(s_ALUOp), .ALUSrc(s_ALUSrc), .MemRead(s_MemRead),
    .MemWrite(s_MemWrite), .MemtoReg(s_MemtoReg), .RegWrite(s_RegWrite), .Branch(s_Branch),
    .pc_en(s_pc_en), .mem_err(s_mem_err), .illegal(s_illegal), .busy(s_busy),
    .instr_count(s_instr_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an opcode in FETCH; returns with the sequencer in DECODE.
  task automatic fetch(input logic [3:0] op);
    opcode      = op;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  int mem_cycles;

  initial begin
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_aluop", ALUOp, 3'h7);
    check("rst_ready", instr_ready, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_mem", {MemRead, MemWrite}, 0);
    check("rst_count", instr_count, 0);

    reset_n = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("fetch_ready", instr_ready, 1);
    check("fetch_busy", busy, 1);

    // ADD: DECODE, EXEC, WB
    fetch(4'd2);
    check("add_dec_ready", instr_ready, 0);
    check("add_dec_aluop", ALUOp, 3'h7);
    check("add_dec_illegal", illegal, 0);
    step();
    check("add_exec_aluop", ALUOp, 3'd2);
    check("add_exec_pc_en", pc_en, 0);
    step();
    check("add_wb_pc_en", pc_en, 1);
    check("add_wb_regwrite", RegWrite, 1);
    check("add_wb_memtoreg", MemtoReg, 0);
    check("add_wb_aluop", ALUOp, 3'd2);
    step();
    check("add_count", instr_count, 1);
    check("add_sat_count", s_instr_count, 1);
    check("add_fetch_ready", instr_ready, 1);
    check("add_fetch_aluop", ALUOp, 3'h7);
    check("add_fetch_pc_en", pc_en, 0);

    // LDR, mem_ready raised in the third MEM cycle
    fetch(4'd0);
    step();
    check("ldr_exec_aluop", ALUOp, 3'd0);
    check("ldr_exec_memread", MemRead, 0);
    step();
    check("ldr_mem1_read", MemRead, 1);
    check("ldr_mem1_write", MemWrite, 0);
    step();
    check("ldr_mem2_read", MemRead, 1);
    step();
    check("ldr_mem3_read", MemRead, 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("ldr_wb_memread", MemRead, 0);
    check("ldr_wb_memtoreg", MemtoReg, 1);
    check("ldr_wb_regwrite", RegWrite, 1);
    check("ldr_wb_pc_en", pc_en, 1);
    check("ldr_wb_mem_err", mem_err, 0);
    step();
    check("ldr_count", instr_count, 2);

    // STR with mem_ready never asserted: timeout after 16 MEM cycles
    fetch(4'd1);
    step();
    step();
    mem_cycles = 0;
    for (int i = 0; i < 40 && MemWrite; i++) begin
      mem_cycles++;
      if (MemRead) check("str_memread_low", MemRead, 0);
      step();
    end
    check("str_mem_cycles", mem_cycles, 16);
    check("str_wb_mem_err", mem_err, 1);
    check("str_wb_regwrite", RegWrite, 0);
    check("str_wb_pc_en", pc_en, 1);
    check("str_wb_memwrite", MemWrite, 0);
    step();
    check("str_err_pulse", mem_err, 0);
    check("str_count", instr_count, 3);

    // BR taken: br_logic=1 during DECODE, dropped afterwards
    fetch(4'd7);
    br_logic = 1'b1;
    step();
    br_logic = 1'b0;
    check("br1_exec_aluop", ALUOp, 3'd7);
    step();
    check("br1_wb_branch", Branch, 1);
    check("br1_wb_regwrite", RegWrite, 0);
    check("br1_wb_pc_en", pc_en, 1);
    step();
    check("br1_fetch_branch", Branch, 0);

    // BR not taken: br_logic rises only after DECODE
    fetch(4'd7);
    br_logic = 1'b0;
    step();
    br_logic = 1'b1;
    step();
    br_logic = 1'b0;
    check("br0_wb_branch", Branch, 0);
    check("br0_wb_pc_en", pc_en, 1);
    step();
    check("br0_count", instr_count, 5);
    check("sat_count_5", s_instr_count, 3);

    // Illegal opcode 9: NOP that still retires
    fetch(4'd9);
    check("ill_dec_illegal", illegal, 1);
    step();
    check("ill_exec_illegal", illegal, 0);
    check("ill_exec_aluop", ALUOp, 3'h7);
    step();
    check("ill_wb_regwrite", RegWrite, 0);
    check("ill_wb_pc_en", pc_en, 1);
    check("ill_wb_branch", Branch, 0);
    step();
    check("ill_count", instr_count, 6);
    check("sat_count_6", s_instr_count, 3);

    // halt_req ignored when an opcode is accepted on the same edge
    halt_req = 1'b1;
    fetch(4'd3);
    halt_req = 1'b0;
    check("halt_ign_busy", busy, 1);
    step();
    check("xor_exec_aluop", ALUOp, 3'd3);
    step();
    check("xor_wb_regwrite", RegWrite, 1);
    step();
    check("xor_count", instr_count, 7);

    // halt_req alone in FETCH returns to IDLE
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_busy", busy, 0);
    check("halt_ready", instr_ready, 0);
    step();
    check("halt_stays_idle", busy, 0);

    // Reset during the MEM phase of a STR
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(4'd1);
    step();
    step();
    step();
    check("rmem_memwrite", MemWrite, 1);
    reset_n = 1'b0;
    step();
    check("rmem_memwrite_drop", MemWrite, 0);
    check("rmem_busy", busy, 0);
    check("rmem_count", instr_count, 0);
    check("rmem_sat_count", s_instr_count, 0);
    check("rmem_pc_en", pc_en, 0);
    check("rmem_aluop", ALUOp, 3'h7);
    reset_n = 1'b1;
    step();
    check("rmem_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
